// File: rtl/vsa16_pkg.sv
// ============================================================================
// Module   : vsa16_pkg
// Purpose  : Shared types and constants for the VSA16 memory arbiter
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vsa16_pkg;

    localparam int PC_W    = 12;
    localparam int DATA_W  = 16;
    localparam int MADDR_W = 15;

    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_IF   = 2'd1;
    localparam logic [1:0] GNT_D    = 2'd2;
    localparam logic [1:0] GNT_DMA  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/vsa16_mem_arbiter_if.sv
// ============================================================================
// Module   : vsa16_mem_arbiter_if
// Purpose  : Requester and memory-side bundle of the VSA16 memory arbiter
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vsa16_mem_arbiter_if;
    import vsa16_pkg::*;

    logic                 if_req;
    logic [PC_W-1:0]      if_addr;
    logic                 if_ack;
    logic [DATA_W-1:0]    if_rdata;

    logic                 d_req;
    logic                 d_we;
    logic [DATA_W-1:0]    d_addr;
    logic [DATA_W-1:0]    d_wdata;
    logic                 d_ack;
    logic [DATA_W-1:0]    d_rdata;

    logic                 dma_req;
    logic                 dma_we;
    logic [DATA_W-1:0]    dma_addr;
    logic [DATA_W-1:0]    dma_wdata;
    logic                 dma_ack;
    logic [DATA_W-1:0]    dma_rdata;

    logic                 mem_req;
    logic                 mem_we;
    logic [MADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]    mem_wdata;
    logic [DATA_W-1:0]    mem_rdata;
    logic                 mem_ready;

    logic [1:0]           grant_id;
    logic                 timeout_err;

    // Arbiter view: serves the requesters and drives the memory.
    modport slave (
        input  if_req, if_addr,
        input  d_req, d_we, d_addr, d_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        input  mem_rdata, mem_ready,
        output if_ack, if_rdata, d_ack, d_rdata, dma_ack, dma_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output grant_id, timeout_err
    );

    // Environment view: requesters plus memory model.
    modport master (
        output if_req, if_addr,
        output d_req, d_we, d_addr, d_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        output mem_rdata, mem_ready,
        input  if_ack, if_rdata, d_ack, d_rdata, dma_ack, dma_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  grant_id, timeout_err
    );

endinterface

`default_nettype wire

// File: rtl/vsa16_prio_sel.sv
// ============================================================================
// Module   : vsa16_prio_sel
// Purpose  : Fixed-priority select (D > IF > DMA) with DMA starvation promotion
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vsa16_prio_sel
    import vsa16_pkg::*;
(
    input  wire logic       i_if_req,
    input  wire logic       i_d_req,
    input  wire logic       i_dma_req,
    input  wire logic       i_starve_hit,
    output logic [2:0]      o_winner,     // one-hot {dma, d, if}
    output logic [1:0]      o_grant_id
);

    always_comb begin
        o_winner   = 3'b000;
        o_grant_id = GNT_NONE;
        if (i_dma_req && i_starve_hit) begin
            o_winner   = 3'b100;
            o_grant_id = GNT_DMA;
        end else if (i_d_req) begin
            o_winner   = 3'b010;
            o_grant_id = GNT_D;
        end else if (i_if_req) begin
            o_winner   = 3'b001;
            o_grant_id = GNT_IF;
        end else if (i_dma_req) begin
            o_winner   = 3'b100;
            o_grant_id = GNT_DMA;
        end
    end

endmodule

`default_nettype wire

// File: rtl/vsa16_mem_arbiter.sv
// ============================================================================
// Module   : vsa16_mem_arbiter
// Purpose  : Serialises IF / D / DMA accesses onto one variable-latency memory
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vsa16_mem_arbiter
    import vsa16_pkg::*;
#(
    parameter int STARVE_LIMIT = 8,
    parameter int TIMEOUT      = 15
) (
    input  wire logic           clock,
    input  wire logic           rst,
    vsa16_mem_arbiter_if.slave  bus
);

    localparam logic [7:0] c_STARVE_LIMIT = 8'(STARVE_LIMIT);
    localparam logic [7:0] c_TIMEOUT      = 8'(TIMEOUT);

    arb_state_t           r_state;
    logic [7:0]           r_starve_cnt;
    logic [7:0]           r_tmo_cnt;
    logic                 r_mem_req;
    logic                 r_mem_we;
    logic [MADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]    r_mem_wdata;
    logic [1:0]           r_grant_id;
    logic                 r_timeout_err;
    logic                 r_if_ack, r_d_ack, r_dma_ack;
    logic [DATA_W-1:0]    r_if_rdata, r_d_rdata, r_dma_rdata;

    logic [2:0]           w_winner;
    logic [1:0]           w_gnt;
    logic                 w_starve_hit;
    logic                 w_any_req;
    logic [7:0]           w_tmo_next;
    logic                 w_done;
    logic [DATA_W-1:0]    w_cap;
    logic [DATA_W-1:0]    w_if_baddr;
    logic                 w_unused_addr_lsb;

    assign w_starve_hit = (r_starve_cnt == c_STARVE_LIMIT);
    assign w_any_req    = bus.if_req | bus.d_req | bus.dma_req;
    assign w_tmo_next   = (r_tmo_cnt == 8'hFF) ? r_tmo_cnt : r_tmo_cnt + 8'd1;
    assign w_done       = bus.mem_ready | (w_tmo_next == c_TIMEOUT);
    // A timed-out access returns zero data.
    assign w_cap        = bus.mem_ready ? bus.mem_rdata : '0;
    assign w_if_baddr   = {{(DATA_W-PC_W){1'b0}}, bus.if_addr};
    assign w_unused_addr_lsb = ^{w_if_baddr[0], bus.d_addr[0], bus.dma_addr[0]};

    vsa16_prio_sel u_prio_sel (
        .i_if_req     (bus.if_req),
        .i_d_req      (bus.d_req),
        .i_dma_req    (bus.dma_req),
        .i_starve_hit (w_starve_hit),
        .o_winner     (w_winner),
        .o_grant_id   (w_gnt)
    );

    always_ff @(posedge clock) begin
        if (rst) begin
            r_state       <= IDLE;
            r_starve_cnt  <= '0;
            r_tmo_cnt     <= '0;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_grant_id    <= GNT_NONE;
            r_timeout_err <= 1'b0;
            r_if_ack      <= 1'b0;
            r_d_ack       <= 1'b0;
            r_dma_ack     <= 1'b0;
            r_if_rdata    <= '0;
            r_d_rdata     <= '0;
            r_dma_rdata   <= '0;
        end else begin
            r_if_ack  <= 1'b0;
            r_d_ack   <= 1'b0;
            r_dma_ack <= 1'b0;
            if (!bus.dma_req) begin
                r_starve_cnt <= '0;
            end
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_state    <= WAIT;
                        r_mem_req  <= 1'b1;
                        r_grant_id <= w_gnt;
                        r_tmo_cnt  <= '0;
                        if (w_winner[1]) begin
                            r_mem_we    <= bus.d_we;
                            r_mem_addr  <= bus.d_addr[DATA_W-1:1];
                            r_mem_wdata <= bus.d_wdata;
                        end else if (w_winner[2]) begin
                            r_mem_we    <= bus.dma_we;
                            r_mem_addr  <= bus.dma_addr[DATA_W-1:1];
                            r_mem_wdata <= bus.dma_wdata;
                        end else begin
                            r_mem_we    <= 1'b0;
                            r_mem_addr  <= w_if_baddr[DATA_W-1:1];
                            r_mem_wdata <= '0;
                        end
                        if (bus.dma_req) begin
                            if (w_winner[2]) begin
                                r_starve_cnt <= '0;
                            end else if (r_starve_cnt != 8'hFF) begin
                                r_starve_cnt <= r_starve_cnt + 8'd1;
                            end
                        end
                    end
                end
                WAIT: begin
                    r_tmo_cnt <= w_tmo_next;
                    if (w_done) begin
                        r_mem_req <= 1'b0;
                        r_state   <= RESP;
                        if (!bus.mem_ready) begin
                            r_timeout_err <= 1'b1;
                        end
                        case (r_grant_id)
                            GNT_IF: begin
                                r_if_rdata <= w_cap;
                                r_if_ack   <= 1'b1;
                            end
                            GNT_D: begin
                                r_d_rdata <= w_cap;
                                r_d_ack   <= 1'b1;
                            end
                            GNT_DMA: begin
                                r_dma_rdata <= w_cap;
                                r_dma_ack   <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                RESP: begin
                    r_grant_id <= GNT_NONE;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.if_ack      = r_if_ack;
    assign bus.if_rdata    = r_if_rdata;
    assign bus.d_ack       = r_d_ack;
    assign bus.d_rdata     = r_d_rdata;
    assign bus.dma_ack     = r_dma_ack;
    assign bus.dma_rdata   = r_dma_rdata;
    assign bus.mem_req     = r_mem_req;
    assign bus.mem_we      = r_mem_we;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_wdata   = r_mem_wdata;
    assign bus.grant_id    = r_grant_id;
    assign bus.timeout_err = r_timeout_err;

endmodule

`default_nettype wire

// File: tb/tb_vsa16_mem_arbiter.sv
// ============================================================================
// Module   : tb_vsa16_mem_arbiter
// Purpose  : Directed scoreboard bench for vsa16_mem_arbiter
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vsa16_mem_arbiter;
    import vsa16_pkg::*;

    typedef struct {
        logic [1:0]  gid;
        logic        we;
        logic [14:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        logic        chk;
    } exp_t;

    logic clock = 1'b0;
    logic rst   = 1'b1;

    vsa16_mem_arbiter_if bus();

    vsa16_mem_arbiter #(.STARVE_LIMIT(8), .TIMEOUT(15)) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    exp_t        acc_q[$];
    exp_t        sb[$];
    logic [15:0] mem [0:32767];
    int tests = 0, fails = 0, cyc = 0;
    int lat = 1, wcnt = 0;
    int if_left = 0, d_left = 0, dma_left = 0;
    int rise_cyc = 0, ack_cyc = 0, d_ack_cyc = 0, run_start = 0;
    logic prev_req = 1'b0;

    function automatic logic [15:0] pat(input logic [14:0] w);
        return {1'b0, w} ^ 16'h3C5A;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic expect_acc(input logic [1:0] gid, input logic we, input logic [14:0] addr,
                              input logic [15:0] wdata, input logic [15:0] rdata,
                              input logic chk, input logic acked);
        exp_t e;
        e.gid = gid; e.we = we; e.addr = addr; e.wdata = wdata; e.rdata = rdata; e.chk = chk;
        acc_q.push_back(e);
        if (acked) sb.push_back(e);
    endtask

    // One negedge: scoreboard monitor, requester release, memory model.
    task automatic tick();
        logic [1:0]  ogid;
        logic [15:0] rd;
        exp_t        e;
        @(negedge clock);
        cyc++;
        if (bus.mem_req && !prev_req) begin
            rise_cyc = cyc;
            if (acc_q.size() == 0) begin
                check("unexpected_access", 128'(bus.mem_req), 128'(1'b0));
            end else begin
                e = acc_q.pop_front();
                check("mem_fields", 128'({bus.grant_id, bus.mem_we, bus.mem_addr, bus.mem_wdata}),
                      128'({e.gid, e.we, e.addr, e.wdata}));
            end
        end
        prev_req = bus.mem_req;
        if (bus.if_ack || bus.d_ack || bus.dma_ack) begin
            ack_cyc = cyc;
            case ({bus.dma_ack, bus.d_ack, bus.if_ack})
                3'b001:  ogid = GNT_IF;
                3'b010:  ogid = GNT_D;
                3'b100:  ogid = GNT_DMA;
                default: ogid = GNT_NONE;
            endcase
            if (sb.size() == 0) begin
                check("unexpected_ack", 128'({bus.dma_ack, bus.d_ack, bus.if_ack}), 128'(3'b000));
            end else begin
                e = sb.pop_front();
                check("ack_owner", 128'(ogid), 128'(e.gid));
                check("ack_grant_id", 128'(bus.grant_id), 128'(e.gid));
                check("ack_mem_req_low", 128'(bus.mem_req), 128'(1'b0));
                if (e.chk) begin
                    case (e.gid)
                        GNT_IF:  rd = bus.if_rdata;
                        GNT_D:   rd = bus.d_rdata;
                        default: rd = bus.dma_rdata;
                    endcase
                    check("ack_rdata", 128'(rd), 128'(e.rdata));
                end
            end
            if (bus.if_ack && if_left > 0) begin
                if_left--;
                if (if_left == 0) bus.if_req = 1'b0;
            end
            if (bus.d_ack) d_ack_cyc = cyc;
            if (bus.d_ack && d_left > 0) begin
                d_left--;
                if (d_left == 0) bus.d_req = 1'b0;
            end
            if (bus.dma_ack && dma_left > 0) begin
                dma_left--;
                if (dma_left == 0) bus.dma_req = 1'b0;
            end
        end
        if (bus.mem_req) begin
            if (lat != 0 && wcnt >= lat - 1) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = mem[bus.mem_addr];
                if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
                wcnt = 0;
            end else begin
                bus.mem_ready = 1'b0;
                bus.mem_rdata = 16'($urandom);
                wcnt++;
            end
        end else begin
            bus.mem_ready = 1'b0;
            bus.mem_rdata = 16'($urandom);
            wcnt = 0;
        end
    endtask

    task automatic run(input int n_if, input int n_d, input int n_dma, input int budget);
        int n = 0;
        if_left = n_if; d_left = n_d; dma_left = n_dma;
        bus.if_req  = (n_if > 0);
        bus.d_req   = (n_d > 0);
        bus.dma_req = (n_dma > 0);
        run_start = cyc;
        while ((if_left + d_left + dma_left) > 0 && n < budget) begin
            tick();
            n++;
        end
        check("run_complete", 128'(if_left + d_left + dma_left), 128'(0));
        if_left = 0; d_left = 0; dma_left = 0;
        bus.if_req = 1'b0; bus.d_req = 1'b0; bus.dma_req = 1'b0;
    endtask

    function automatic logic [86:0] all_outs();
        return {bus.if_ack, bus.if_rdata, bus.d_ack, bus.d_rdata, bus.dma_ack, bus.dma_rdata,
                bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.grant_id, bus.timeout_err};
    endfunction

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = pat(15'(i));
        mem[2] = 16'hA5A5;
        bus.if_req = 1'b0;  bus.if_addr = '0;
        bus.d_req = 1'b0;   bus.d_we = 1'b0;   bus.d_addr = '0;   bus.d_wdata = '0;
        bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0;
        bus.mem_ready = 1'b0; bus.mem_rdata = '0;

        // Reset and idle
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("reset_outputs", 128'(all_outs()), 128'(0));
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_outputs", 128'(all_outs()), 128'(0));
        end

        // Single fetch, immediate memory
        lat = 1;
        bus.if_addr = 12'h004;
        expect_acc(GNT_IF, 1'b0, 15'h0002, 16'h0000, 16'hA5A5, 1'b1, 1'b1);
        run(1, 0, 0, 20);
        check("fetch_mem_req_latency", 128'(rise_cyc - run_start), 128'(1));
        check("fetch_ack_latency", 128'(ack_cyc - run_start), 128'(2));
        tick(); tick();

        // Contention: D store wins, IF follows after one bubble
        lat = 3;
        bus.d_we = 1'b1; bus.d_addr = 16'h0100; bus.d_wdata = 16'h1234;
        bus.if_addr = 12'h010;
        expect_acc(GNT_D, 1'b1, 15'h0080, 16'h1234, 16'h0000, 1'b0, 1'b1);
        expect_acc(GNT_IF, 1'b0, 15'h0008, 16'h0000, pat(15'h0008), 1'b1, 1'b1);
        run(1, 1, 0, 40);
        check("contention_bubble", 128'(rise_cyc - d_ack_cyc), 128'(2));
        check("contention_wait_len", 128'(ack_cyc - rise_cyc), 128'(3));
        tick(); tick();

        // DMA reads back the stored word
        lat = 2;
        bus.dma_we = 1'b0; bus.dma_addr = 16'h0100; bus.dma_wdata = 16'hBEEF;
        expect_acc(GNT_DMA, 1'b0, 15'h0080, 16'hBEEF, 16'h1234, 1'b1, 1'b1);
        run(0, 0, 1, 20);
        tick(); tick();

        // Anti-starvation: DMA promoted after exactly 8 lost arbitrations
        lat = 1;
        bus.d_we = 1'b0; bus.d_addr = 16'h0200; bus.d_wdata = 16'h5555;
        bus.if_addr = 12'h020;
        bus.dma_we = 1'b1; bus.dma_addr = 16'h0300; bus.dma_wdata = 16'hCAFE;
        for (int i = 0; i < 6; i++)
            expect_acc(GNT_D, 1'b0, 15'h0100, 16'h5555, pat(15'h0100), 1'b1, 1'b1);
        for (int i = 0; i < 2; i++)
            expect_acc(GNT_IF, 1'b0, 15'h0010, 16'h0000, pat(15'h0010), 1'b1, 1'b1);
        expect_acc(GNT_DMA, 1'b1, 15'h0180, 16'hCAFE, 16'h0000, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++)
            expect_acc(GNT_IF, 1'b0, 15'h0010, 16'h0000, pat(15'h0010), 1'b1, 1'b1);
        run(6, 6, 1, 100);
        tick(); tick();

        // Timeout on a stalled load
        check("timeout_err_clear", 128'(bus.timeout_err), 128'(1'b0));
        lat = 0;
        bus.d_we = 1'b0; bus.d_addr = 16'h0400; bus.d_wdata = 16'h7777;
        expect_acc(GNT_D, 1'b0, 15'h0200, 16'h7777, 16'h0000, 1'b1, 1'b1);
        run(0, 1, 0, 40);
        check("timeout_wait_len", 128'(ack_cyc - rise_cyc), 128'(15));
        tick();
        check("timeout_err_set", 128'(bus.timeout_err), 128'(1'b1));
        lat = 1;
        bus.if_addr = 12'h004;
        expect_acc(GNT_IF, 1'b0, 15'h0002, 16'h0000, 16'hA5A5, 1'b1, 1'b1);
        run(1, 0, 0, 20);
        tick();
        check("timeout_err_sticky", 128'(bus.timeout_err), 128'(1'b1));
        tick();

        // Reset in the second WAIT cycle abandons the access
        lat = 0;
        bus.d_we = 1'b0; bus.d_addr = 16'h0600; bus.d_wdata = 16'h0000;
        expect_acc(GNT_D, 1'b0, 15'h0300, 16'h0000, 16'h0000, 1'b0, 1'b0);
        bus.d_req = 1'b1;
        tick();
        check("abort_first_wait", 128'(bus.mem_req), 128'(1'b1));
        tick();
        rst = 1'b1;
        bus.d_req = 1'b0;
        tick();
        check("abort_state", 128'({bus.mem_req, bus.grant_id, bus.timeout_err,
                                   bus.if_ack, bus.d_ack, bus.dma_ack}), 128'(0));
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        lat = 1;
        bus.if_addr = 12'h006;
        expect_acc(GNT_IF, 1'b0, 15'h0003, 16'h0000, pat(15'h0003), 1'b1, 1'b1);
        run(1, 0, 0, 20);
        check("post_reset_ack_latency", 128'(ack_cyc - run_start), 128'(2));
        tick(); tick();

        check("scoreboard_drained", 128'(sb.size() + acc_q.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vsa16_mem_arbiter.md
Name: vsa16_mem_arbiter

Overview:
Shares one single-ported, variable-latency unified memory among three requesters: the VSA16 instruction-fetch path, the VSA16 data path (LW/SW), and a DMA/debug port. The block sits between the processor core and the memory model. It serialises accesses, applies fixed priority with DMA anti-starvation, and converts memory wait states into one-cycle acknowledge pulses. Stalling the core is done through the acknowledges; the core must hold each request until it is acknowledged.

Parameters:
STARVE_LIMIT, 8, number of consecutive lost arbitrations after which a waiting DMA request is promoted to highest priority (1..255)
TIMEOUT, 15, maximum cycles in WAIT without mem_ready before the access is aborted with an error (1..255)

Ports:
clock  in  1  master clock, all state on posedge
rst  in  1  synchronous, active-high reset
if_req  in  1  instruction fetch request
if_addr  in  12  fetch byte address (the core's PC)
if_ack  out  1  one-cycle pulse: if_rdata valid
if_rdata  out  16  fetched instruction
d_req  in  1  data access request
d_we  in  1  1 = store (SW), 0 = load (LW)
d_addr  in  16  data byte address (the core's ALUOutput)
d_wdata  in  16  store data (the core's dataout)
d_ack  out  1  one-cycle pulse: access done, d_rdata valid on loads
d_rdata  out  16  load data
dma_req  in  1  DMA request
dma_we  in  1  DMA write enable
dma_addr  in  16  DMA byte address
dma_wdata  in  16  DMA write data
dma_ack  out  1  one-cycle completion pulse
dma_rdata  out  16  DMA read data
mem_req  out  1  memory access strobe, held until mem_ready
mem_we  out  1  memory write enable
mem_addr  out  15  memory word address, equal to byte address [15:1]
mem_wdata  out  16  memory write data
mem_rdata  in  16  memory read data, valid when mem_ready
mem_ready  in  1  memory completion, sampled only while mem_req=1
grant_id  out  2  owner of the current access: 0 none, 1 IF, 2 D, 3 DMA
timeout_err  out  1  sticky flag: some access has timed out

Behaviour:
- Reset: every output is 0. State is IDLE, the starvation counter is 0, the timeout counter is 0, and timeout_err is 0. A reset asserted mid-access abandons the access: mem_req is 0 after that edge and no acknowledge is ever issued for the abandoned access.
- The FSM has three states: IDLE, WAIT and RESP. All outputs are registered.
- IDLE, with any request present:
  - Select a winner and latch its we, addr and wdata into the mem_* registers. Set mem_req=1 and grant_id for the next cycle, then go to WAIT.
  - if_addr is zero-extended to 16 bits before the [15:1] slice; if_we is implicitly 0.
- Priority: D > IF > DMA. Exception: when starve_cnt==STARVE_LIMIT and dma_req=1, DMA wins.
- Starvation counter:
  - Increments (saturating) on each IDLE arbitration that DMA loses while dma_req=1.
  - Clears when DMA is granted, or in any cycle where dma_req=0.
- WAIT:
  - mem_req is held at 1 and the timeout counter increments each cycle.
  - On mem_ready=1: capture mem_rdata into the winner's rdata register, drop mem_req, and go to RESP.
  - On timeout (counter reaches TIMEOUT with no mem_ready): drop mem_req, set the winner's rdata to 0, set timeout_err=1, and go to RESP.
- RESP:
  - The winner's ack is 1 for exactly this cycle.
  - grant_id returns to 0 and the FSM returns to IDLE. A new arbitration happens in the following cycle, so back-to-back accesses are separated by one bubble.
- Latency: with the request sampled at edge N and mem_ready=1 in the first WAIT cycle, mem_req is high after N+1, the ack is high after N+2, and the next mem_req rises after N+4.
- rdata registers hold their last value until overwritten. rdata is don't-care when d_we or dma_we is 1.
- Requester contract: req and its fields stay stable until ack. A req deasserted before ack is a protocol violation. The arbiter still completes the access and pulses ack.
- Simultaneous requests: all losers stay pending. No request is ever dropped, and requests are never merged.
- mem_ready outside WAIT is ignored.
- Widths: counters are 8 bits and saturating. Address slicing truncates bit 0 (byte addresses are assumed even).

Decomposition:
- Shared package vsa16_pkg holds:
  - the FSM state enum {IDLE, WAIT, RESP};
  - the grant_id encodings GNT_NONE, GNT_IF, GNT_D, GNT_DMA;
  - the address-width constants PC_W=12, DATA_W=16, MADDR_W=15.
- One natural sub-module, vsa16_prio_sel: a combinational priority/promotion select. Inputs are the three reqs and starve_hit; outputs are a one-hot winner and grant_id. The top level keeps the FSM, the counters and the datapath registers.

Test Plan:
- Reset and idle: with rst=1 for 2 cycles, then no requests for 10 cycles, every output stays 0 and mem_req never rises.
- Single fetch with mem_ready immediate: if_req=1 and if_addr=12'h004, memory returns 16'hA5A5. Required: mem_addr=15'h0002 one cycle after the request, if_ack pulses 2 cycles after the request, and if_rdata=16'hA5A5.
- Contention with a 3-cycle memory: if_req and d_req are raised in the same cycle, with d_we=1, d_addr=16'h0100 and d_wdata=16'h1234. The D access runs first, with mem_we=1, mem_addr=15'h0080 and mem_wdata=16'h1234. The IF access follows after d_ack and a one-cycle bubble.
- Anti-starvation: dma_req is held while D and IF alternately re-request continuously, with STARVE_LIMIT=8. Required: dma_ack occurs after exactly 8 lost arbitrations, with grant_id=3 at that point.
- Timeout: d_req is a load and mem_ready is held at 0. Required: after TIMEOUT=15 WAIT cycles, mem_req drops, d_ack pulses with d_rdata=0, and timeout_err=1 and stays 1 until rst.
- Reset mid-access: assert rst in the second WAIT cycle. Required: mem_req=0 and grant_id=0 after the edge, no ack is ever seen, and a fresh request afterwards completes normally.
